// File: rtl/ctrl_squash_unit_if.sv
// Handshake bundle between the ID-stage decoder/hazard logic and the ID/EX
// control squash register. The hazard side is the master; the squash unit
// is the slave.
interface ctrl_squash_unit_if #(
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
);

  logic [CTRL_W-1:0] ctrl_in;
  logic              flush_req;
  logic [CNT_W-1:0]  flush_len;
  logic              stall;

  logic [CTRL_W-1:0] ctrl_out;
  logic              bubble;
  logic              busy;
  logic              sq_done;
  logic [PERF_W-1:0] sq_count;

  modport master (
    output ctrl_in,
    output flush_req,
    output flush_len,
    output stall,
    input  ctrl_out,
    input  bubble,
    input  busy,
    input  sq_done,
    input  sq_count
  );

  modport slave (
    input  ctrl_in,
    input  flush_req,
    input  flush_len,
    input  stall,
    output ctrl_out,
    output bubble,
    output busy,
    output sq_done,
    output sq_count
  );

endinterface

// File: rtl/ctrl_squash_unit.sv
// ID/EX control register with squash (bubble) insertion.
// A flush request replaces the control bundle with a bubble for an
// effective length of 1..MAX_SQ cycles; stalls freeze the register and the
// remaining window. Every output comes straight from a flop.
module ctrl_squash_unit #(
  parameter int                CTRL_W    = 10,
  parameter int                MAX_SQ    = 3,
  parameter int                CNT_W     = 2,   // must satisfy 2**CNT_W > MAX_SQ
  parameter logic [CTRL_W-1:0] KEEP_MASK = '0,
  parameter int                PERF_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_squash_unit_if.slave  sq
);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MAX_L = CNT_W'(MAX_SQ);
  localparam logic [PERF_W-1:0] SAT   = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               bubble_q, bubble_d;
  logic               done_q, done_d;
  logic [PERF_W-1:0]  cnt_q, cnt_d;

  logic [CNT_W-1:0]   eff_len;
  logic [CTRL_W-1:0]  bubble_bundle;
  logic               load_bubble;

  // Clamp the requested length into 1..MAX_SQ; zero means a single bubble.
  always_comb begin
    eff_len = sq.flush_len;
    if (sq.flush_len == '0) begin
      eff_len = ONE;
    end else if (sq.flush_len > MAX_L) begin
      eff_len = MAX_L;
    end
  end

  // Squashed bundle: only the KEEP_MASK bits survive.
  assign bubble_bundle = sq.ctrl_in & KEEP_MASK;

  // Next-state, next-output and bubble-issue decision.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    rem_d       = rem_q;
    ctrl_d      = ctrl_q;
    bubble_d    = bubble_q;
    done_d      = 1'b0;
    load_bubble = 1'b0;

    if (sq.flush_req) begin
      // A flush always wins over stall and restarts the window from scratch.
      load_bubble = 1'b1;
      ctrl_d      = bubble_bundle;
      bubble_d    = 1'b1;
      if (eff_len == ONE) begin
        state_d = RUN;
        rem_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d = SQUASH;
        rem_d   = eff_len - ONE;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (!sq.stall) begin
            ctrl_d   = sq.ctrl_in;
            bubble_d = 1'b0;
          end
        end
        SQUASH: begin
          if (!sq.stall) begin
            load_bubble = 1'b1;
            ctrl_d      = bubble_bundle;
            bubble_d    = 1'b1;
            rem_d       = rem_q - ONE;
            if (rem_q == ONE) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Saturating count of issued bubbles; holds never count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_bubble && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and output registers; reset aborts any window immediately.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= RUN;
      rem_q    <= '0;
      ctrl_q   <= '0;
      bubble_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      ctrl_q   <= ctrl_d;
      bubble_q <= bubble_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sq.ctrl_out = ctrl_q;
  assign sq.bubble   = bubble_q;
  assign sq.busy     = (state_q == SQUASH);
  assign sq.sq_done  = done_q;
  assign sq.sq_count = cnt_q;

endmodule

// File: tb/tb_ctrl_squash_unit.sv
// Self-checking bench for ctrl_squash_unit. Two instances share stimulus:
// A uses the defaults, B uses MAX_SQ=2, KEEP_MASK=10'h001, PERF_W=2.
// A bubble-budget model predicts every output; directed scenarios pin it.
module tb_ctrl_squash_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       t_fr = 1'b0;
  logic [1:0] t_fl = '0;
  logic       t_st = 1'b0;
  logic [9:0] t_ci = '0;

  ctrl_squash_unit_if #(.CTRL_W(10), .CNT_W(2), .PERF_W(16)) a_if ();
  ctrl_squash_unit_if #(.CTRL_W(10), .CNT_W(2), .PERF_W(2))  b_if ();

  assign a_if.ctrl_in   = t_ci;
  assign a_if.flush_req = t_fr;
  assign a_if.flush_len = t_fl;
  assign a_if.stall     = t_st;
  assign b_if.ctrl_in   = t_ci;
  assign b_if.flush_req = t_fr;
  assign b_if.flush_len = t_fl;
  assign b_if.stall     = t_st;

  ctrl_squash_unit #(.CTRL_W(10), .MAX_SQ(3), .CNT_W(2),
                     .KEEP_MASK(10'h000), .PERF_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .sq    (a_if.slave)
  );

  ctrl_squash_unit #(.CTRL_W(10), .MAX_SQ(2), .CNT_W(2),
                     .KEEP_MASK(10'h001), .PERF_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .sq    (b_if.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // left = bubbles still owed after the current one; busy means left > 0.
  int m_out[2], m_bub[2], m_done[2], m_cnt[2], m_left[2];

  function automatic int max_sq_of(int i);  return (i == 0) ? 3 : 2;      endfunction
  function automatic int keep_of(int i);    return (i == 0) ? 0 : 1;      endfunction
  function automatic int cnt_max_of(int i); return (i == 0) ? 65535 : 3;  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_bub[i] = 0; m_done[i] = 0; m_cnt[i] = 0; m_left[i] = 0;
    end
  end

  always @(posedge clk or posedge reset) begin
    int len;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_out[i] = 0; m_bub[i] = 0; m_done[i] = 0; m_cnt[i] = 0; m_left[i] = 0;
      end else if (t_fr) begin
        len = (t_fl == 0) ? 1 : ((int'(t_fl) > max_sq_of(i)) ? max_sq_of(i) : int'(t_fl));
        m_out[i]  = int'(t_ci) & keep_of(i);
        m_bub[i]  = 1;
        m_cnt[i]  = (m_cnt[i] < cnt_max_of(i)) ? m_cnt[i] + 1 : m_cnt[i];
        m_left[i] = len - 1;
        m_done[i] = (m_left[i] == 0) ? 1 : 0;
      end else if (t_st) begin
        m_done[i] = 0;
      end else if (m_left[i] > 0) begin
        m_out[i]  = int'(t_ci) & keep_of(i);
        m_bub[i]  = 1;
        m_cnt[i]  = (m_cnt[i] < cnt_max_of(i)) ? m_cnt[i] + 1 : m_cnt[i];
        m_left[i] = m_left[i] - 1;
        m_done[i] = (m_left[i] == 0) ? 1 : 0;
      end else begin
        m_out[i]  = int'(t_ci);
        m_bub[i]  = 0;
        m_done[i] = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_ctrl_out", 64'(a_if.ctrl_out), 64'(m_out[0]));
      check("a_bubble",   64'(a_if.bubble),   64'(m_bub[0]));
      check("a_busy",     64'(a_if.busy),     64'(m_left[0] > 0));
      check("a_sq_done",  64'(a_if.sq_done),  64'(m_done[0]));
      check("a_sq_count", 64'(a_if.sq_count), 64'(m_cnt[0]));
      check("b_ctrl_out", 64'(b_if.ctrl_out), 64'(m_out[1]));
      check("b_bubble",   64'(b_if.bubble),   64'(m_bub[1]));
      check("b_busy",     64'(b_if.busy),     64'(m_left[1] > 0));
      check("b_sq_done",  64'(b_if.sq_done),  64'(m_done[1]));
      check("b_sq_count", 64'(b_if.sq_count), 64'(m_cnt[1]));
    end
  end

  // Drive one cycle of inputs from a negedge, return at the next negedge.
  task automatic cyc(input bit fr, input logic [1:0] fl, input bit st, input logic [9:0] ci);
    t_fr = fr; t_fl = fl; t_st = st; t_ci = ci;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_ctrl_out"}, 64'(a_if.ctrl_out), 64'(0));
    check({tag, "_a_bubble"},   64'(a_if.bubble),   64'(0));
    check({tag, "_a_busy"},     64'(a_if.busy),     64'(0));
    check({tag, "_a_sq_done"},  64'(a_if.sq_done),  64'(0));
    check({tag, "_a_sq_count"}, 64'(a_if.sq_count), 64'(0));
    check({tag, "_b_ctrl_out"}, 64'(b_if.ctrl_out), 64'(0));
    check({tag, "_b_sq_count"}, 64'(b_if.sq_count), 64'(0));
  endtask

  initial begin
    // Reset and its state.
    #1 reset = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Pass-through.
    cyc(1'b0, 2'd0, 1'b0, 10'h2A5);
    check("pass_ctrl_out", 64'(a_if.ctrl_out), 64'h2A5);
    check("pass_bubble",   64'(a_if.bubble),   64'd0);

    // Three-cycle squash on A (B clamps to two).
    cyc(1'b1, 2'd3, 1'b0, 10'h155);
    check("sq3_n_bubble", 64'(a_if.bubble),   64'd1);
    check("sq3_n_busy",   64'(a_if.busy),     64'd1);
    check("sq3_n_ctrl",   64'(a_if.ctrl_out), 64'h000);
    check("b_keep_155",   64'(b_if.ctrl_out), 64'h001);
    cyc(1'b0, 2'd0, 1'b0, 10'h0FF);
    check("sq3_n1_busy",  64'(a_if.busy),     64'd1);
    check("sq3_n1_done",  64'(a_if.sq_done),  64'd0);
    check("clamp_b_done", 64'(b_if.sq_done),  64'd1);
    cyc(1'b0, 2'd0, 1'b0, 10'h0F0);
    check("sq3_n2_bubble", 64'(a_if.bubble),  64'd1);
    check("sq3_n2_done",  64'(a_if.sq_done),  64'd1);
    check("sq3_n2_busy",  64'(a_if.busy),     64'd0);
    check("sq3_count",    64'(a_if.sq_count), 64'd3);
    check("clamp_b_count", 64'(b_if.sq_count), 64'd2);
    check("clamp_b_ctrl", 64'(b_if.ctrl_out), 64'h0F0);
    cyc(1'b0, 2'd0, 1'b0, 10'h123);
    check("sq3_n3_ctrl",  64'(a_if.ctrl_out), 64'h123);
    check("sq3_n3_bubble", 64'(a_if.bubble),  64'd0);

    // Stall inside a two-cycle squash.
    cyc(1'b1, 2'd2, 1'b0, 10'h3FF);
    check("keep_b_3ff",   64'(b_if.ctrl_out), 64'h001);
    cyc(1'b0, 2'd0, 1'b1, 10'h111);
    cyc(1'b0, 2'd0, 1'b1, 10'h222);
    check("stall_busy",   64'(a_if.busy),     64'd1);
    check("stall_count",  64'(a_if.sq_count), 64'd4);
    cyc(1'b0, 2'd0, 1'b0, 10'h333);
    check("stall_done",   64'(a_if.sq_done),  64'd1);
    check("stall_count2", 64'(a_if.sq_count), 64'd5);

    // Re-flush with length 0 on the second bubble ends the window.
    cyc(1'b1, 2'd3, 1'b0, 10'h044);
    cyc(1'b1, 2'd0, 1'b0, 10'h055);
    check("reflush_done", 64'(a_if.sq_done),  64'd1);
    check("reflush_busy", 64'(a_if.busy),     64'd0);
    check("reflush_cnt",  64'(a_if.sq_count), 64'd7);
    cyc(1'b0, 2'd0, 1'b0, 10'h2A5);
    check("reflush_after", 64'(a_if.bubble),  64'd0);

    // Asynchronous reset in the middle of a squash window.
    cyc(1'b1, 2'd3, 1'b0, 10'h0AA);
    #2 reset = 1'b1;
    #1 check_all_zero("async");
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 2'd0, 1'b0, 10'h2A5);
    check("post_rst_ctrl",   64'(a_if.ctrl_out), 64'h2A5);
    check("post_rst_bubble", 64'(a_if.bubble),   64'd0);

    // Five bubbles saturate B's 2-bit counter.
    cyc(1'b1, 2'd3, 1'b0, 10'h001);
    cyc(1'b0, 2'd0, 1'b0, 10'h002);
    cyc(1'b1, 2'd3, 1'b0, 10'h003);
    cyc(1'b0, 2'd0, 1'b0, 10'h004);
    cyc(1'b1, 2'd1, 1'b0, 10'h005);
    check("sat_b_count", 64'(b_if.sq_count), 64'd3);
    check("sat_a_count", 64'(a_if.sq_count), 64'd5);
    cyc(1'b0, 2'd0, 1'b0, 10'h006);

    // Randomised traffic with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        t_fr = 1'b0; t_st = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        cyc($urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, 10'($urandom_range(0, 1023)));
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ctrl_squash_unit.md
CTRL_SQUASH_UNIT -- requirements
Module: ctrl_squash_unit

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CTRL_W, default 10, giving the width of the control bundle (RegDst..ALUOp packing).
REQ-002 The block SHALL have parameter MAX_SQ, default 3, giving the maximum bubble length in cycles (>=1).
REQ-003 The block SHALL have parameter CNT_W, default 2, giving the width of flush_len and the internal counter, which SHALL satisfy 2^CNT_W > MAX_SQ.
REQ-004 The block SHALL have parameter KEEP_MASK, default all-zero CTRL_W bits; bits set to 1 pass through during a bubble and are not forced to 0.
REQ-005 The block SHALL have parameter PERF_W, default 16, giving the width of the squash performance counter.

Ports (name, direction, width, meaning):
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  reset, asynchronous and active-high.
REQ-008 ctrl_in  input  CTRL_W  decoded ID-stage control bundle.
REQ-009 flush_req  input  1  request a squash on this edge.
REQ-010 flush_len  input  CNT_W  requested bubble length in cycles.
REQ-011 stall  input  1  hold the ID/EX control register.
REQ-012 ctrl_out  output  CTRL_W  registered control bundle to EX.
REQ-013 bubble  output  1  ctrl_out currently carries a squashed bundle.
REQ-014 busy  output  1  a squash window is active, in state SQUASH.
REQ-015 sq_done  output  1  one-cycle pulse on the last bubble cycle.
REQ-016 sq_count  output  PERF_W  total bubble cycles issued since reset.

Function
REQ-017 The FSM SHALL have two states, RUN and SQUASH; rem (CNT_W) SHALL hold the bubble cycles still to issue after the current one.
REQ-018 The effective length SHALL be L = 1 if flush_len = 0, MAX_SQ if flush_len > MAX_SQ, and flush_len otherwise.
REQ-019 A bubble bundle SHALL be ctrl_in AND KEEP_MASK.
REQ-020 Edge priority SHALL be: reset, then flush_req, then stall, then normal operation.
REQ-021 In RUN with flush_req=1, the next ctrl_out SHALL be a bubble with bubble=1; if L=1, the state SHALL stay RUN and sq_done=1; otherwise the state SHALL go to SQUASH with rem=L-1.
REQ-022 In RUN with flush_req=0 and stall=1, ctrl_out and bubble SHALL hold their values.
REQ-023 In RUN with flush_req=0 and stall=0, ctrl_out SHALL be ctrl_in and bubble=0.
REQ-024 In SQUASH with flush_req=0 and stall=1, ctrl_out, rem and the state SHALL be frozen, and sq_count SHALL NOT increment.
REQ-025 In SQUASH with flush_req=0 and stall=0, the block SHALL issue a bubble and decrement rem; when rem reaches 0, sq_done=1 on that cycle and the next state SHALL be RUN.
REQ-026 flush_req=1 while in SQUASH SHALL reload the window: issue a bubble and set rem=L-1, ignoring the old remainder; if L=1, the next state SHALL be RUN with sq_done=1.
REQ-027 Total bubble cycles SHALL equal L counted from the last accepted flush_req, excluding stalled cycles.
REQ-028 Latency SHALL be 1 cycle: a flush_req sampled at edge n SHALL make ctrl_out a bubble from edge n.
REQ-029 sq_count SHALL increment once per edge that loads a new bubble (not on holds) and SHALL saturate at 2^PERF_W-1 without wrapping.
REQ-030 busy SHALL equal (state == SQUASH), and sq_done SHALL be registered and asserted for exactly one cycle per completed window.
REQ-031 Outputs SHALL depend only on registered state, with no combinational path from inputs to outputs.

Reset
REQ-032 Asserting reset SHALL immediately set ctrl_out=0, bubble=0, busy=0, sq_done=0, sq_count=0, rem=0 and state=RUN, regardless of clk.
REQ-033 Reset asserted mid-SQUASH SHALL abort the window, and after release the block SHALL resume from RUN with no residual bubbles.
REQ-034 On the first edge after reset release, the block SHALL apply normal RUN rules.

Verification
REQ-035 Pass-through: CTRL_W=10, ctrl_in=10'h2A5 with no flush or stall -> ctrl_out=10'h2A5 one cycle later, bubble=0.
REQ-036 Multi-cycle squash: flush_len=3 at edge n -> bubble=1 at n, n+1 and n+2; sq_done=1 at n+2; busy=1 at n and n+1; ctrl_out=ctrl_in at n+3; sq_count=3.
REQ-037 Stall inside squash: flush_len=2, then stall for 2 cycles after the first bubble -> exactly 2 bubbles issued, window ends 2 cycles later, sq_count=2.
REQ-038 Re-flush and clamp: flush_len=3, then flush_req with flush_len=0 on the second bubble -> window ends that cycle with sq_done=1; flush_len=3 with MAX_SQ=2 -> 2 bubbles only.
REQ-039 KEEP_MASK=10'h001 with ctrl_in=10'h3FF under flush -> ctrl_out=10'h001.
REQ-040 Async reset mid-SQUASH between edges -> all outputs 0 immediately; PERF_W=2 with 5 bubbles -> sq_count=3.
